// File: rtl/mpi_rendezvous_tx.sv
// MPI rendezvous sender: envelope, wait for CTS, data header plus payload,
// wait for DONE or error, then report a single completion pulse.
module mpi_rendezvous_tx #(
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [15:0]             req_dst_rank,
  input  logic [7:0]              req_src_rank,
  input  logic [15:0]             req_size,
  input  logic [7:0]              req_tag,
  input  logic [DATA_WIDTH-1:0]   data_in_data,
  input  logic [DATA_WIDTH/8-1:0] data_in_keep,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  output logic [DATA_WIDTH-1:0]   stream_out_data,
  output logic [DATA_WIDTH/8-1:0] stream_out_keep,
  output logic                    stream_out_last,
  output logic                    stream_out_valid,
  input  logic                    stream_out_ready,
  input  logic [DATA_WIDTH-1:0]   stream_in_data,
  input  logic [DATA_WIDTH/8-1:0] stream_in_keep,
  input  logic                    stream_in_last,
  input  logic                    stream_in_valid,
  output logic                    stream_in_ready,
  output logic                    done_valid,
  output logic                    done_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int TW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0] T_ENV  = 8'd0;
  localparam logic [7:0] T_CTS  = 8'd1;
  localparam logic [7:0] T_DATA = 8'd2;
  localparam logic [7:0] T_ERR  = 8'd4;
  localparam logic [7:0] T_DONE = 8'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_ENV,
    S_WAIT_CTS,
    S_SEND_DHDR,
    S_SEND_DATA,
    S_WAIT_DONE,
    S_REPORT
  } state_t;

  state_t        r_state;
  logic [15:0]   r_dst;
  logic [7:0]    r_src;
  logic [15:0]   r_size;
  logic [7:0]    r_tag;
  logic [15:0]   r_beats;
  logic [TW-1:0] r_tmo;
  logic          r_first;
  logic          r_err;
  logic          r_live;

  logic [7:0]       w_type;
  logic [63:0]      w_hdr;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_addr_ok;
  logic             w_eval;
  logic [7:0]       w_in_type;
  logic             w_cts;
  logic             w_done_ok;
  logic             w_done_bad;
  logic             w_expired;
  logic             w_last_beat;
  logic [BSH-1:0]   w_rem;
  logic [BYTES-1:0] w_mask;
  logic [16:0]      w_ceil;
  logic [16:0]      w_shift;
  logic [15:0]      w_beats;
  logic             w_unused;

  assign w_type = (r_state == S_SEND_DHDR) ? T_DATA : T_ENV;
  assign w_hdr  = {8'd1, r_tag, r_size, w_type, r_src, r_dst};

  assign w_in_fire  = stream_in_valid & stream_in_ready;
  assign w_out_fire = stream_out_valid & stream_out_ready;

  // Only the first beat of a packet is inspected; the rest is drained.
  assign w_in_type = stream_in_data[31:24];
  assign w_addr_ok = (stream_in_data[23:16] == r_dst[7:0]) &&
                     (stream_in_data[15:0] == {8'd0, r_src});
  assign w_eval    = w_in_fire & r_first & w_addr_ok;

  assign w_cts      = w_eval && (r_state == S_WAIT_CTS) &&
                      (w_in_type == T_CTS);
  assign w_done_ok  = w_eval && (r_state == S_WAIT_DONE) &&
                      (w_in_type == T_DONE);
  assign w_done_bad = w_eval && (r_state == S_WAIT_DONE) &&
                      (w_in_type == T_ERR);

  assign w_expired   = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_last_beat = (r_beats == 16'd1);

  assign w_rem   = r_size[BSH-1:0];
  assign w_ceil  = {1'b0, r_size} + 17'(BYTES - 1);
  assign w_shift = w_ceil >> BSH;
  assign w_beats = w_shift[15:0];

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < BYTES; i++)
      w_mask[i] = (w_rem == '0) || (i < int'(w_rem));
  end

  assign w_unused = ^{stream_in_keep, w_shift[16],
                      stream_in_data[DATA_WIDTH-1:32]};

  assign req_ready       = (r_state == S_IDLE) && r_live;
  assign stream_in_ready = (r_state == S_WAIT_CTS) ||
                           (r_state == S_WAIT_DONE);
  assign done_valid      = (r_state == S_REPORT);
  assign done_error      = (r_state == S_REPORT) && r_err;

  always_comb begin
    stream_out_valid = 1'b0;
    stream_out_data  = '0;
    stream_out_keep  = '0;
    stream_out_last  = 1'b0;
    data_in_ready    = 1'b0;
    case (r_state)
      S_SEND_ENV: begin
        stream_out_valid       = 1'b1;
        stream_out_data[63:0]  = w_hdr;
        stream_out_keep        = '1;
        stream_out_last        = 1'b1;
      end
      S_SEND_DHDR: begin
        stream_out_valid       = 1'b1;
        stream_out_data[63:0]  = w_hdr;
        stream_out_keep        = '1;
        stream_out_last        = (r_size == 16'd0);
      end
      S_SEND_DATA: begin
        stream_out_valid = data_in_valid;
        stream_out_data  = data_in_data;
        stream_out_keep  = w_last_beat ? w_mask : data_in_keep;
        stream_out_last  = w_last_beat;
        data_in_ready    = stream_out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_dst   <= '0;
      r_src   <= '0;
      r_size  <= '0;
      r_tag   <= '0;
      r_beats <= '0;
      r_tmo   <= '0;
      r_first <= 1'b1;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_in_fire)
        r_first <= stream_in_last;
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_dst   <= req_dst_rank;
            r_src   <= req_src_rank;
            r_size  <= req_size;
            r_tag   <= req_tag;
            r_err   <= 1'b0;
            r_state <= S_SEND_ENV;
          end
        end
        S_SEND_ENV: begin
          if (w_out_fire) begin
            r_tmo   <= '0;
            r_state <= S_WAIT_CTS;
          end
        end
        S_WAIT_CTS: begin
          if (w_cts) begin
            r_state <= S_SEND_DHDR;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= S_REPORT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_SEND_DHDR: begin
          if (w_out_fire) begin
            if (r_size == 16'd0) begin
              r_tmo   <= '0;
              r_state <= S_WAIT_DONE;
            end else begin
              r_beats <= w_beats;
              r_state <= S_SEND_DATA;
            end
          end
        end
        S_SEND_DATA: begin
          if (w_out_fire) begin
            r_beats <= r_beats - 16'd1;
            if (w_last_beat) begin
              r_tmo   <= '0;
              r_state <= S_WAIT_DONE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (w_done_ok) begin
            r_err   <= 1'b0;
            r_state <= S_REPORT;
          end else if (w_done_bad || w_expired) begin
            r_err   <= 1'b1;
            r_state <= S_REPORT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_REPORT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpi_rendezvous_tx.sv
// Directed bench for mpi_rendezvous_tx: a 64-bit instance with a short
// timeout and a 256-bit instance driven with a random output ready.
module tb_mpi_rendezvous_tx;

  logic clk     = 1'b0;
  logic aresetn = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic        a_req_valid, a_req_ready;
  logic [15:0] a_dst;
  logic [7:0]  a_src;
  logic [15:0] a_size;
  logic [7:0]  a_tag;
  logic [63:0] a_di_data;
  logic [7:0]  a_di_keep;
  logic        a_di_valid, a_di_ready;
  logic [63:0] a_so_data;
  logic [7:0]  a_so_keep;
  logic        a_so_last, a_so_valid, a_so_ready;
  logic [63:0] a_si_data;
  logic [7:0]  a_si_keep;
  logic        a_si_last, a_si_valid, a_si_ready;
  logic        a_done_valid, a_done_error;

  logic         b_req_valid, b_req_ready;
  logic [15:0]  b_dst;
  logic [7:0]   b_src;
  logic [15:0]  b_size;
  logic [7:0]   b_tag;
  logic [255:0] b_di_data;
  logic [31:0]  b_di_keep;
  logic         b_di_valid, b_di_ready;
  logic [255:0] b_so_data;
  logic [31:0]  b_so_keep;
  logic         b_so_last, b_so_valid, b_so_ready;
  logic [255:0] b_si_data;
  logic [31:0]  b_si_keep;
  logic         b_si_last, b_si_valid, b_si_ready;
  logic         b_done_valid, b_done_error;

  mpi_rendezvous_tx #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) u_a (
    .clk(clk), .aresetn(aresetn),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_dst_rank(a_dst), .req_src_rank(a_src),
    .req_size(a_size), .req_tag(a_tag),
    .data_in_data(a_di_data), .data_in_keep(a_di_keep),
    .data_in_valid(a_di_valid), .data_in_ready(a_di_ready),
    .stream_out_data(a_so_data), .stream_out_keep(a_so_keep),
    .stream_out_last(a_so_last), .stream_out_valid(a_so_valid),
    .stream_out_ready(a_so_ready),
    .stream_in_data(a_si_data), .stream_in_keep(a_si_keep),
    .stream_in_last(a_si_last), .stream_in_valid(a_si_valid),
    .stream_in_ready(a_si_ready),
    .done_valid(a_done_valid), .done_error(a_done_error)
  );

  mpi_rendezvous_tx #(.DATA_WIDTH(256), .TIMEOUT_CYCLES(64)) u_b (
    .clk(clk), .aresetn(aresetn),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_dst_rank(b_dst), .req_src_rank(b_src),
    .req_size(b_size), .req_tag(b_tag),
    .data_in_data(b_di_data), .data_in_keep(b_di_keep),
    .data_in_valid(b_di_valid), .data_in_ready(b_di_ready),
    .stream_out_data(b_so_data), .stream_out_keep(b_so_keep),
    .stream_out_last(b_so_last), .stream_out_valid(b_so_valid),
    .stream_out_ready(b_so_ready),
    .stream_in_data(b_si_data), .stream_in_keep(b_si_keep),
    .stream_in_last(b_si_last), .stream_in_valid(b_si_valid),
    .stream_in_ready(b_si_ready),
    .done_valid(b_done_valid), .done_error(b_done_error)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic [15:0] d, input logic [7:0] s,
                       input logic [15:0] sz, input logic [7:0] t);
    a_dst = d; a_src = s; a_size = sz; a_tag = t;
    a_req_valid = 1'b1;
    #1;
    chk("a_req_ready", a_req_ready, 1);
    step();
    a_req_valid = 1'b0;
    #1;
  endtask

  task automatic a_beat_in(input logic [63:0] d, input logic l);
    a_si_data = d; a_si_last = l; a_si_valid = 1'b1;
    #1;
    chk("a_si_ready", a_si_ready, 1);
    step();
    a_si_valid = 1'b0; a_si_data = '0; a_si_last = 1'b0;
    #1;
  endtask

  task automatic a_data(input logic [63:0] d, input logic [7:0] k,
                        input logic [7:0] ek, input logic el);
    a_di_data = d; a_di_keep = k; a_di_valid = 1'b1;
    #1;
    chk("a_data", a_so_data, d);
    chk("a_data_keep", a_so_keep, ek);
    chk("a_data_last", a_so_last, el);
    chk("a_di_ready", a_di_ready, 1);
    step();
    a_di_valid = 1'b0;
  endtask

  function automatic logic [255:0] b_beat(input int k);
    return {8{32'hA500_0000 + 32'(k)}};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    logic fired;
    a_req_valid = 0; a_dst = 0; a_src = 0; a_size = 0; a_tag = 0;
    a_di_data = 0; a_di_keep = 0; a_di_valid = 0; a_so_ready = 0;
    a_si_data = 0; a_si_keep = '1; a_si_last = 0; a_si_valid = 0;
    b_req_valid = 0; b_dst = 0; b_src = 0; b_size = 0; b_tag = 0;
    b_di_data = 0; b_di_keep = 0; b_di_valid = 0; b_so_ready = 0;
    b_si_data = 0; b_si_keep = '1; b_si_last = 0; b_si_valid = 0;

    #1 aresetn = 1'b0;
    #1;
    chk("rst_req_ready", a_req_ready, 0);
    chk("rst_so_valid", a_so_valid, 0);
    chk("rst_so_data", a_so_data, 0);
    chk("rst_so_keep", a_so_keep, 0);
    chk("rst_so_last", a_so_last, 0);
    chk("rst_si_ready", a_si_ready, 0);
    chk("rst_di_ready", a_di_ready, 0);
    chk("rst_done", {a_done_valid, a_done_error}, 0);
    @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    step();
    chk("rel_req_ready", a_req_ready, 1);
    chk("rel_b_req_ready", b_req_ready, 1);

    // basic transfer: dst 3, src 1, 20 bytes
    a_req(16'd3, 8'd1, 16'd20, 8'd0);
    chk("t1_env", a_so_data, 64'h0100_0014_0001_0003);
    chk("t1_env_last", a_so_last, 1);
    chk("t1_env_valid", a_so_valid, 1);
    chk("t1_env_keep", a_so_keep, 8'hFF);
    chk("t1_req_ready_busy", a_req_ready, 0);
    step();
    chk("t1_env_hold", a_so_data, 64'h0100_0014_0001_0003);
    chk("t1_env_hold_valid", a_so_valid, 1);
    a_so_ready = 1'b1;
    step();
    chk("t1_wcts_valid", a_so_valid, 0);
    chk("t1_wcts_di_ready", a_di_ready, 0);
    a_beat_in(64'h0000_0000_0103_0001, 1'b1);
    chk("t1_dhdr", a_so_data, 64'h0100_0014_0201_0003);
    chk("t1_dhdr_last", a_so_last, 0);
    chk("t1_dhdr_valid", a_so_valid, 1);
    chk("t1_dhdr_si_ready", a_si_ready, 0);
    step();
    a_data(64'h1111_2222_3333_4444, 8'hFF, 8'hFF, 1'b0);
    a_data(64'h5555_6666_7777_8888, 8'hFF, 8'hFF, 1'b0);
    a_data(64'h9999_AAAA_BBBB_CCCC, 8'h01, 8'h0F, 1'b1);
    #1;
    chk("t1_wdone_di_ready", a_di_ready, 0);
    chk("t1_wdone_valid", a_so_valid, 0);
    a_beat_in(64'h0000_0000_0503_0001, 1'b1);
    chk("t1_done", {a_done_valid, a_done_error}, 2'b10);
    step();
    chk("t1_done_pulse", a_done_valid, 0);
    chk("t1_idle_ready", a_req_ready, 1);

    // zero-length payload
    a_di_valid = 1'b1;
    a_req(16'd3, 8'd1, 16'd0, 8'd7);
    chk("t2_env", a_so_data, 64'h0107_0000_0001_0003);
    chk("t2_env_di_ready", a_di_ready, 0);
    step();
    a_beat_in(64'h0000_0000_0103_0001, 1'b1);
    chk("t2_dhdr", a_so_data, 64'h0107_0000_0201_0003);
    chk("t2_dhdr_last", a_so_last, 1);
    chk("t2_dhdr_di_ready", a_di_ready, 0);
    step();
    chk("t2_wdone_di_ready", a_di_ready, 0);
    chk("t2_wdone_valid", a_so_valid, 0);
    a_di_valid = 1'b0;
    a_beat_in(64'h0000_0000_0503_0001, 1'b1);
    chk("t2_done", {a_done_valid, a_done_error}, 2'b10);
    step();

    // foreign 2-beat packet ahead of the real CTS; then RECV_ERROR
    a_req(16'd3, 8'd1, 16'd8, 8'd2);
    step();
    a_beat_in(64'h0000_0000_0102_0001, 1'b0);
    a_beat_in(64'h0000_0000_0103_0001, 1'b1);
    chk("t3_discard_si_ready", a_si_ready, 1);
    chk("t3_discard_valid", a_so_valid, 0);
    a_beat_in(64'h0000_0000_0103_0001, 1'b1);
    chk("t3_dhdr", a_so_data, 64'h0102_0008_0201_0003);
    chk("t3_dhdr_valid", a_so_valid, 1);
    step();
    a_data(64'hDEAD_BEEF_0000_0001, 8'hFF, 8'hFF, 1'b1);
    #1;
    a_beat_in(64'h0000_0000_0403_0001, 1'b1);
    chk("t3_err_done", {a_done_valid, a_done_error}, 2'b11);
    step();

    // CTS timeout, 16 cycles
    a_req(16'd3, 8'd1, 16'd4, 8'd0);
    step();
    chk("t4_wcts_si_ready", a_si_ready, 1);
    for (int i = 1; i < 16; i++) step();
    chk("t4_before_expire", a_done_valid, 0);
    chk("t4_before_si_ready", a_si_ready, 1);
    step();
    chk("t4_timeout_done", {a_done_valid, a_done_error}, 2'b11);
    step();
    chk("t4_back_idle", a_req_ready, 1);

    // reset during second payload beat
    a_req(16'd3, 8'd1, 16'd24, 8'd0);
    step();
    a_beat_in(64'h0000_0000_0103_0001, 1'b1);
    step();
    a_data(64'h0123_4567_89AB_CDEF, 8'hFF, 8'hFF, 1'b0);
    a_di_data = 64'hFEDC_BA98_7654_3210;
    a_di_valid = 1'b1;
    #1;
    chk("t5_beat2_valid", a_so_valid, 1);
    aresetn = 1'b0;
    #1;
    chk("t5_rst_so", {a_so_valid, a_so_last, a_so_keep}, 0);
    chk("t5_rst_so_data", a_so_data, 0);
    chk("t5_rst_readies", {a_si_ready, a_di_ready, a_req_ready}, 0);
    chk("t5_rst_done", {a_done_valid, a_done_error}, 0);
    step();
    chk("t5_rst_hold_done", a_done_valid, 0);
    aresetn = 1'b1;
    a_di_valid = 1'b0;
    step();
    chk("t5_rel_ready", a_req_ready, 1);
    chk("t5_rel_no_done", a_done_valid, 0);
    a_req(16'h0105, 8'd9, 16'd9, 8'hAB);
    chk("t5_env", a_so_data, 64'h01AB_0009_0009_0105);
    step();
    a_beat_in(64'h0000_0000_0105_0009, 1'b1);
    chk("t5_dhdr", a_so_data, 64'h01AB_0009_0209_0105);
    chk("t5_dhdr_last", a_so_last, 0);
    step();
    a_data(64'hAAAA_0000_BBBB_0001, 8'hFF, 8'hFF, 1'b0);
    a_data(64'hAAAA_0000_BBBB_0002, 8'hFF, 8'h01, 1'b1);
    #1;
    a_beat_in(64'h0000_0000_0505_0009, 1'b1);
    chk("t5_done", {a_done_valid, a_done_error}, 2'b10);
    step();

    // 256-bit instance, 70 bytes, random output ready
    b_dst = 16'd3; b_src = 8'd1; b_size = 16'd70; b_tag = 8'd0;
    b_req_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
    #1;
    chk("b_env", b_so_data, 256'h0100_0046_0001_0003);
    chk("b_env_keep", b_so_keep, 32'hFFFF_FFFF);
    b_so_ready = 1'b1;
    step();
    b_si_data = 256'h0000_0000_0103_0001;
    b_si_last = 1'b1;
    b_si_valid = 1'b1;
    #1;
    chk("b_si_ready", b_si_ready, 1);
    step();
    b_si_valid = 1'b0;
    #1;
    chk("b_dhdr", b_so_data, 256'h0100_0046_0201_0003);
    chk("b_dhdr_last", b_so_last, 0);
    step();
    k = 0;
    for (int c = 0; c < 200 && k < 3; c++) begin
      b_di_data  = b_beat(k);
      b_di_keep  = '1;
      b_di_valid = 1'b1;
      b_so_ready = (c == 0) ? 1'b0 : 1'(($urandom_range(0, 1)));
      #1;
      chk("b_beat_data", b_so_data, b_beat(k));
      chk("b_beat_valid", b_so_valid, 1);
      chk("b_beat_last", b_so_last, (k == 2));
      chk("b_beat_keep", b_so_keep, (k == 2) ? 32'h3F : 32'hFFFF_FFFF);
      chk("b_di_ready", b_di_ready, b_so_ready);
      fired = b_so_valid & b_so_ready;
      step();
      if (fired) k++;
    end
    b_di_valid = 1'b0;
    #1;
    chk("b_beat_count", k, 3);
    chk("b_wdone", {b_so_valid, b_si_ready}, 2'b01);
    b_si_data = 256'h0000_0000_0503_0001;
    b_si_valid = 1'b1;
    step();
    b_si_valid = 1'b0;
    #1;
    chk("b_done", {b_done_valid, b_done_error}, 2'b10);
    step();
    chk("b_idle", b_req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
